// File: rtl/toeplitz_seq_pkg.sv
// -----------------------------------------------------------------------------
// toeplitz_pkg
// Shared definitions for the Toeplitz extractor sequencer:
//   - controller state encoding
//   - default geometry (N, L, STRIDE, SW) and the constants derived from it
//   - helper for sizing counters
// -----------------------------------------------------------------------------
package toeplitz_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ARM  = 3'd2,
        RUN  = 3'd3,
        OUT  = 3'd4
    } state_e;

    // Default geometry
    localparam int N_DEF      = 256;
    localparam int L_DEF      = 128;
    localparam int STRIDE_DEF = 1;
    localparam int SW_DEF     = 64;

    // Derived constants for the default geometry
    localparam int BEATS      = N_DEF / STRIDE_DEF;
    localparam int SEED_WORDS = (N_DEF + L_DEF) / SW_DEF;

    // Width of a counter that must hold values 0..n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/toeplitz_seq_if.sv
// -----------------------------------------------------------------------------
// toeplitz_seq_if
// Bundles the three streams of the sequencer (seed words, raw beats, hashed
// output) together with the generator control/seed signals.
//   slave  : the sequencer (toeplitz_seq)
//   master : the environment (seed source, raw source, generators, sink)
// Signals:
//   seed_data/seed_valid/seed_ready  seed word stream (SW bits)
//   rrow0/col0                       seed row/column to the generators
//   gen_restart/gen_en               generator reload pulse / step enable
//   cols                             STRIDE generator columns, L bits each
//   in_data/in_valid/in_ready        raw beat stream (STRIDE bits)
//   out_data/out_valid/out_ready     hashed word stream (L bits)
//   busy                             controller not idle
// -----------------------------------------------------------------------------
interface toeplitz_seq_if
    import toeplitz_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int L      = L_DEF,
    parameter int STRIDE = STRIDE_DEF,
    parameter int SW     = SW_DEF
);
    logic [SW-1:0]       seed_data;
    logic                seed_valid;
    logic                seed_ready;
    logic [N-1:0]        rrow0;
    logic [L-1:0]        col0;
    logic                gen_restart;
    logic                gen_en;
    logic [STRIDE*L-1:0] cols;
    logic [STRIDE-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic [L-1:0]        out_data;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    modport slave (
        input  seed_data, seed_valid, cols, in_data, in_valid, out_ready,
        output seed_ready, rrow0, col0, gen_restart, gen_en, in_ready,
               out_data, out_valid, busy
    );

    modport master (
        output seed_data, seed_valid, cols, in_data, in_valid, out_ready,
        input  seed_ready, rrow0, col0, gen_restart, gen_en, in_ready,
               out_data, out_valid, busy
    );
endinterface

// File: rtl/toeplitz_seq_acc.sv
// -----------------------------------------------------------------------------
// toeplitz_acc
// L-bit XOR accumulator. Each enabled cycle folds in every generator column
// whose paired raw bit is 1. clr has priority over en and forces zero.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear
//   en           accumulate this cycle
//   cols         STRIDE columns, slice k = cols[k*L +: L]
//   bits         raw bits, bit k masks slice k
//   acc_q        accumulator register
//   acc_nxt      acc_q with this cycle's contribution (combinational)
// -----------------------------------------------------------------------------
module toeplitz_acc
    import toeplitz_pkg::*;
#(
    parameter int L      = L_DEF,
    parameter int STRIDE = STRIDE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [STRIDE*L-1:0] cols,
    input  logic [STRIDE-1:0]   bits,
    output logic [L-1:0]        acc_q,
    output logic [L-1:0]        acc_nxt
);
    logic [L-1:0] red_s;
    logic [L-1:0] acc_d;

    // Masked XOR-reduce of the selected columns
    always_comb begin
        red_s = '0;
        for (int k = 0; k < STRIDE; k++) begin
            red_s = red_s ^ (cols[k*L +: L] & {L{bits[k]}});
        end
        acc_nxt = acc_q ^ red_s;
    end

    // Next accumulator value: clear wins over accumulate
    always_comb begin
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_nxt;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/toeplitz_seq.sv
// -----------------------------------------------------------------------------
// toeplitz_seq
// Sequencer/accumulator for the Toeplitz extractor column generators.
//   IDLE/LOAD : shift (N+L)/SW seed words into seed_reg (first word ends up
//               in the least significant word)
//   ARM       : one-cycle gen_restart, clears accumulator and beat counter
//   RUN       : one generator step per accepted raw beat, XOR-accumulate;
//               after N/STRIDE beats the result is presented on out_*
//   OUT       : wait for out_ready
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset
//   bus        toeplitz_seq_if.slave (seed, raw and output streams plus
//              generator seed/control)
// Build option:
//   TOEPLITZ_SEQ_DBUF_EN  adds an output holding register so the next block
//                         accumulates while the previous result waits; the
//                         controller only stalls in OUT if a second block
//                         completes before the first was taken.
// Geometry requires N % STRIDE == 0, (N+L) % SW == 0 and at least two seed
// words.
// -----------------------------------------------------------------------------
module toeplitz_seq
    import toeplitz_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int L      = L_DEF,
    parameter int STRIDE = STRIDE_DEF,
    parameter int SW     = SW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    toeplitz_seq_if.slave  bus
);
    localparam int NBEATS = N / STRIDE;
    localparam int NWORDS = (N + L) / SW;
    localparam int BW     = cnt_width(NBEATS);
    localparam int WW     = cnt_width(NWORDS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(NWORDS - 1);

    state_e         state_q, state_d;
    logic [N+L-1:0] seed_q, seed_d;
    logic [WW-1:0]  word_cnt_q, word_cnt_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [L-1:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;

    logic [L-1:0]   acc_q_s;
    logic [L-1:0]   acc_nxt_s;
    logic           acc_clr_s;
    logic           seed_ready_s;
    logic           in_ready_s;
    logic           gen_restart_s;
    logic           seed_fire_s;
    logic           beat_fire_s;
    logic           out_fire_s;
    logic [N+L-1:0] seed_shift_s;

    // New words enter at the top so the first word drifts down to bit 0
    assign seed_shift_s = {bus.seed_data, seed_q[N+L-1:SW]};

    assign seed_fire_s = bus.seed_valid & seed_ready_s;
    assign beat_fire_s = bus.in_valid & in_ready_s;
    assign out_fire_s  = out_valid_q & bus.out_ready;

    // Handshake readiness and generator reload decoded from the state
    always_comb begin
        seed_ready_s  = 1'b0;
        in_ready_s    = 1'b0;
        gen_restart_s = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                seed_ready_s = 1'b1;
            end
            ARM: begin
                gen_restart_s = 1'b1;
            end
            RUN: begin
                // A reseed is only possible on a block boundary; when a seed
                // word is offered there it takes precedence over raw data.
                seed_ready_s = (beat_cnt_q == '0);
                in_ready_s   = ~(seed_ready_s & bus.seed_valid);
            end
            OUT: begin
                in_ready_s = 1'b0;
            end
            default: begin
                seed_ready_s = 1'b0;
            end
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        word_cnt_d = word_cnt_q;
        beat_cnt_d = beat_cnt_q;
        out_data_d = out_data_q;
        acc_clr_s  = 1'b0;
        if (out_fire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (seed_fire_s) begin
                    seed_d     = seed_shift_s;
                    word_cnt_d = WW'(1'b1);
                    state_d    = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (seed_fire_s) begin
                    seed_d = seed_shift_s;
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        state_d    = ARM;
                    end else begin
                        word_cnt_d = word_cnt_q + WW'(1'b1);
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            ARM: begin
                acc_clr_s  = 1'b1;
                beat_cnt_d = '0;
                state_d    = RUN;
            end
            RUN: begin
                if (seed_fire_s) begin
                    seed_d     = seed_shift_s;
                    word_cnt_d = WW'(1'b1);
                    state_d    = LOAD;
                end else if (beat_fire_s) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
`ifdef TOEPLITZ_SEQ_DBUF_EN
                        if (!out_valid_q || bus.out_ready) begin
                            out_data_d  = acc_nxt_s;
                            out_valid_d = 1'b1;
                            acc_clr_s   = 1'b1;
                        end else begin
                            // Holding register still occupied: keep the
                            // finished block in the accumulator and stall.
                            state_d = OUT;
                        end
`else
                        out_data_d  = acc_nxt_s;
                        out_valid_d = 1'b1;
                        acc_clr_s   = 1'b1;
                        state_d     = OUT;
`endif
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1'b1);
                    end
                end else begin
                    state_d = RUN;
                end
            end
            OUT: begin
                if (out_fire_s) begin
`ifdef TOEPLITZ_SEQ_DBUF_EN
                    out_data_d  = acc_q_s;
                    out_valid_d = 1'b1;
                    acc_clr_s   = 1'b1;
`endif
                    state_d = RUN;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            seed_q      <= '0;
            word_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            word_cnt_q  <= word_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    toeplitz_acc #(
        .L      (L),
        .STRIDE (STRIDE)
    ) u_acc (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (acc_clr_s),
        .en      (beat_fire_s),
        .cols    (bus.cols),
        .bits    (bus.in_data),
        .acc_q   (acc_q_s),
        .acc_nxt (acc_nxt_s)
    );

    assign bus.seed_ready  = seed_ready_s;
    assign bus.in_ready    = in_ready_s;
    assign bus.gen_restart = gen_restart_s;
    // Generators step exactly on accepted beats
    assign bus.gen_en      = beat_fire_s;
    assign bus.busy        = (state_q != IDLE);
    assign bus.rrow0       = seed_q[N+L-1:L];
    assign bus.col0        = seed_q[L-1:0];
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
endmodule

// File: tb/tb_toeplitz_seq.sv
// -----------------------------------------------------------------------------
// tb_toeplitz_seq
// Directed bench for toeplitz_seq. One instance uses the default geometry
// (seed loading), a second uses N=8, L=4, STRIDE=1, SW=4 driven by a small
// column generator model. Expected hash values are worked out by hand for
// seed words 5,3,A: col0=0101, rrow0=1010_0011, columns
// c0..c7 = 5,B,6,C,8,1,2,5.
// -----------------------------------------------------------------------------
module tb_toeplitz_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    toeplitz_seq_if def_if ();
    toeplitz_seq_if #(.N(8), .L(4), .STRIDE(1), .SW(4)) sm_if ();

    toeplitz_seq u_def (
        .clk   (clk),
        .reset (reset),
        .bus   (def_if)
    );

    toeplitz_seq #(.N(8), .L(4), .STRIDE(1), .SW(4)) u_sm (
        .clk   (clk),
        .reset (reset),
        .bus   (sm_if)
    );

    localparam int TMO = toeplitz_pkg::BEATS / 8;

    int n_checks = 0;
    int n_fail   = 0;
    int def_restart_cnt = 0;
    int sm_gen_en_cnt   = 0;
    int snap;

    // Column generator model: reload on restart, shift in the next row bit
    // per step, wrap to col0 after the eighth column.
    logic [3:0] gcol = 4'h0;
    logic [2:0] gidx = 3'd0;
    always @(posedge clk) begin
        if (sm_if.gen_restart) begin
            gcol <= sm_if.col0;
            gidx <= 3'd0;
        end else if (sm_if.gen_en) begin
            if (gidx == 3'd7) begin
                gcol <= sm_if.col0;
                gidx <= 3'd0;
            end else begin
                gcol <= {gcol[2:0], sm_if.rrow0[gidx + 3'd1]};
                gidx <= gidx + 3'd1;
            end
        end
    end
    assign sm_if.cols = gcol;

    // Event counters
    always @(negedge clk) begin
        if (def_if.gen_restart) def_restart_cnt <= def_restart_cnt + 1;
        if (sm_if.gen_en)       sm_gen_en_cnt   <= sm_gen_en_cnt + 1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic def_seed(input logic [63:0] w);
        bit done;
        done = 1'b0;
        def_if.seed_data  = w;
        def_if.seed_valid = 1'b1;
        for (int i = 0; i < TMO && !done; i++) begin
            @(negedge clk);
            if (def_if.seed_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        def_if.seed_valid = 1'b0;
        if (!done) check("def_seed_timeout", done, 1);
    endtask

    task automatic sm_seed(input logic [3:0] w);
        bit done;
        done = 1'b0;
        sm_if.seed_data  = w;
        sm_if.seed_valid = 1'b1;
        for (int i = 0; i < TMO && !done; i++) begin
            @(negedge clk);
            if (sm_if.seed_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        sm_if.seed_valid = 1'b0;
        if (!done) check("sm_seed_timeout", done, 1);
    endtask

    task automatic sm_beat(input logic b);
        bit done;
        done = 1'b0;
        sm_if.in_data  = b;
        sm_if.in_valid = 1'b1;
        for (int i = 0; i < TMO && !done; i++) begin
            @(negedge clk);
            if (sm_if.in_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        sm_if.in_valid = 1'b0;
        if (!done) check("sm_beat_timeout", done, 1);
    endtask

    task automatic sm_block(input logic [7:0] pat, input bit bubbles);
        for (int j = 0; j < 8; j++) begin
            if (bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            sm_beat(pat[j]);
        end
    endtask

    task automatic sm_get(input string tag, input logic [3:0] exp);
        bit done;
        done = 1'b0;
        for (int i = 0; i < TMO && !done; i++) begin
            @(negedge clk);
            if (sm_if.out_valid) begin
                check(tag, sm_if.out_data, exp);
                sm_if.out_ready = 1'b1;
                @(posedge clk); #1;
                sm_if.out_ready = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) check({tag, "_timeout"}, done, 1);
    endtask

    initial begin
        // 1: reset held while traffic is offered
        reset = 1'b0;
        def_if.seed_data = 64'h0; def_if.seed_valid = 1'b1;
        def_if.in_data = 1'b0; def_if.in_valid = 1'b1; def_if.out_ready = 1'b1;
        def_if.cols = '0;
        sm_if.seed_data = 4'h0; sm_if.seed_valid = 1'b1;
        sm_if.in_data = 1'b1; sm_if.in_valid = 1'b1; sm_if.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_busy", sm_if.busy, 0);
        check("rst_gen_en", sm_if.gen_en, 0);
        check("rst_restart", sm_if.gen_restart, 0);
        def_if.seed_valid = 1'b0; def_if.in_valid = 1'b0; def_if.out_ready = 1'b0;
        sm_if.seed_valid = 1'b0; sm_if.in_valid = 1'b0; sm_if.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rel_out_valid", sm_if.out_valid, 0);
        check("rel_out_data", sm_if.out_data, 0);
        check("rel_busy", sm_if.busy, 0);
        check("rel_seed_ready", sm_if.seed_ready, 1);
        check("rel_in_ready", sm_if.in_ready, 0);
        check("rel_restart", sm_if.gen_restart, 0);
        check("rel_rrow0", sm_if.rrow0, 0);
        check("rel_col0", sm_if.col0, 0);
        check("rel_def_busy", def_if.busy, 0);
        @(posedge clk); #1;

        // 2: default geometry seed load with gaps
        snap = def_restart_cnt;
        for (int w = 0; w < toeplitz_pkg::SEED_WORDS; w++) begin
            repeat (w % 2) begin
                @(posedge clk); #1;
            end
            if (w == toeplitz_pkg::SEED_WORDS - 1) begin
                check("def_load_in_ready", def_if.in_ready, 0);
                check("def_load_restart", def_if.gen_restart, 0);
                check("def_load_busy", def_if.busy, 1);
            end
            def_seed(64'(w));
        end
        check("def_arm_restart", def_if.gen_restart, 1);
        check("def_arm_in_ready", def_if.in_ready, 0);
        check("def_arm_gen_en", def_if.gen_en, 0);
        @(posedge clk); #1;
        check("def_run_restart", def_if.gen_restart, 0);
        check("def_run_in_ready", def_if.in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("def_restart_count", def_restart_cnt - snap, 1);
        check("def_col0", def_if.col0, {64'd1, 64'd0});
        check("def_rrow0", def_if.rrow0, {64'd5, 64'd4, 64'd3, 64'd2});

        // 3: small geometry, gapless blocks
        sm_seed(4'h5); sm_seed(4'h3); sm_seed(4'hA);
        check("sm_col0", sm_if.col0, 4'h5);
        check("sm_rrow0", sm_if.rrow0, 8'hA3);
        sm_block(8'hFF, 1'b0); sm_get("all_ones", 4'hA);
        sm_block(8'h00, 1'b0); sm_get("all_zeros", 4'h0);
        sm_block(8'h08, 1'b0); sm_get("onehot3", 4'hC);
        sm_block(8'h0F, 1'b0); sm_get("low_half", 4'h4);
        sm_block(8'hF0, 1'b0); sm_get("high_half", 4'hE);

        // 4: same blocks with in_valid bubbles
        snap = sm_gen_en_cnt;
        sm_block(8'hFF, 1'b1); sm_get("bub_all_ones", 4'hA);
        check("bub_gen_en_a", sm_gen_en_cnt - snap, 8);
        snap = sm_gen_en_cnt;
        sm_block(8'h0F, 1'b1); sm_get("bub_low_half", 4'h4);
        check("bub_gen_en_b", sm_gen_en_cnt - snap, 8);

        // 5: output back-pressure
        sm_block(8'hF0, 1'b0);
        check("out_latency", sm_if.out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", sm_if.out_valid, 1);
            check("hold_data", sm_if.out_data, 4'hE);
`ifdef TOEPLITZ_SEQ_DBUF_EN
            check("hold_in_ready", sm_if.in_ready, 1);
`else
            check("hold_in_ready", sm_if.in_ready, 0);
`endif
        end
`ifdef TOEPLITZ_SEQ_DBUF_EN
        @(posedge clk); #1;
        sm_block(8'h00, 1'b0);
        @(negedge clk);
        check("dbuf_stall_in_ready", sm_if.in_ready, 0);
        check("dbuf_stall_data", sm_if.out_data, 4'hE);
        sm_get("dbuf_first", 4'hE);
        sm_get("dbuf_second", 4'h0);
`else
        sm_get("held_word", 4'hE);
`endif

        // 6: reset in the middle of a block
        sm_beat(1'b1); sm_beat(1'b1); sm_beat(1'b1);
        sm_if.in_data  = 1'b1;
        sm_if.in_valid = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", sm_if.busy, 0);
        check("mid_rst_out_valid", sm_if.out_valid, 0);
        check("mid_rst_in_ready", sm_if.in_ready, 0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_reseed_in_ready", sm_if.in_ready, 0);
            check("no_reseed_gen_en", sm_if.gen_en, 0);
            check("no_reseed_idle", sm_if.busy, 0);
        end
        sm_if.in_valid = 1'b0;
        @(posedge clk); #1;
        sm_seed(4'h5); sm_seed(4'h3); sm_seed(4'hA);
        sm_block(8'hFF, 1'b0); sm_get("after_reseed", 4'hA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
